// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Optional memory wait-state handshake is selected by MEM_HANDSHAKE_EN (see multicycle_controller).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_JAL      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } statetype;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Reduced branch set keeps only beq/bne; 010/011 are never valid branches.
  function automatic logic branch_ok(input logic [2:0] f3, input logic full);
    if (full) return (f3 != 3'b010) && (f3 != 3'b011);
    else      return f3[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp, op[5], funct3 and funct7b5 onto the 4-bit ALU control code.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_BR: begin
        case (funct3[2:1])
          2'b10:   alucontrol = ALU_SLT;
          2'b11:   alucontrol = ALU_SLTU;
          default: alucontrol = ALU_SUB;
        endcase
      end
      ALUOP_FN: begin
        case (funct3)
          // op5 distinguishes R-type sub from addi, whose bit 30 is immediate data
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core with a single shared memory port.
// Define MEM_HANDSHAKE_EN to make fetch and memory states wait for MemReady.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit FULL_BRANCH = 1'b1,
  parameter bit SUPPORT_U   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal
);

  statetype   state, next;
  logic       mem_ok;
  logic       pcw, irw, mw, rw, taken;
  logic [1:0] aluop;

`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = MemReady;
`else
  assign mem_ok = 1'b1 | MemReady;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = ~Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = ~Ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next      = state;
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_I;
    aluop     = ALUOP_ADD;
    Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irw       = mem_ok;
        pcw       = mem_ok;
        if (mem_ok) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (op)
          OP_LW, OP_SW:     next = S_MEMADR;
          OP_R:             next = S_EXECR;
          OP_I:             next = S_EXECI;
          OP_JAL:           next = S_JAL;
          OP_BR:            next = branch_ok(funct3, FULL_BRANCH) ? S_BRANCH : S_TRAP;
          OP_LUI, OP_AUIPC: next = SUPPORT_U ? S_EXECU : S_TRAP;
          default:          next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ok) next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_FN;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FN;
        next    = S_ALUWB;
      end
      S_EXECU: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        next    = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        pcw     = 1'b1;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        rw   = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ImmSrc  = IMM_B;
        aluop   = ALUOP_BR;
        pcw     = taken;
        next    = S_FETCH;
      end
      S_TRAP: Illegal = 1'b1;
      default: next = S_FETCH;
    endcase
  end

  // Enables are gated by reset so an aborted instruction never writes state.
  assign PCWrite  = pcw & ~reset;
  assign IRWrite  = irw & ~reset;
  assign MemWrite = mw  & ~reset;
  assign RegWrite = rw  & ~reset;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule
